// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side end of the quad-threaded CPU's 64-bit data-memory port, plus a
// host access port used for program load and result dump. One array is shared
// between the two masters, and an ownership FSM decides who may use it:
//
//   CPU_OWN  : the CPU loads (1-cycle registered latency, write-first) and
//              stores (written at the edge). The host is stalled.
//   DRAIN    : one idle cycle after the SoC raises cpu_hold_i. CPU traffic is
//              ignored and the CPU load data is frozen.
//   HOST_OWN : the host reads and writes through a valid/ready port. Release
//              back to the CPU happens once cpu_hold_i drops and no handshake
//              fires in that cycle.
//
// Handshake (host port): a request transfers in a cycle where host_req_i and
// host_ready_o are both high, sampled at the next rising edge. The host keeps
// host_req_i and its payload stable until that happens; nothing is dropped.
// An accepted read answers with host_rvalid_o high for exactly one cycle,
// together with host_rdata_o, in the cycle after acceptance. Writes produce
// no response.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   d_mem_addr_i      CPU word address (sampled every cycle)
//   d_mem_data_i      CPU store data
//   d_mem_wen_i       CPU store enable
//   d_mem_data_o      CPU load data (registered)
//   cpu_hold_i        SoC holds the CPU and requests host ownership
//   host_own_o        host owns the array
//   host_req_i        host request valid
//   host_wen_i        1 = write, 0 = read
//   host_addr_i       host word address
//   host_wdata_i      host write data
//   host_ready_o      host request accepted when high together with host_req_i
//   host_rvalid_o     one-cycle pulse marking host_rdata_o valid
//   host_rdata_o      host read data (registered)
//
// The array is never reset. Reset clears the FSM and all output registers,
// discards a pending read response, and blocks writes in the reset cycle.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] d_mem_addr_i,
    input  logic [DATA_WIDTH-1:0] d_mem_data_i,
    input  logic                  d_mem_wen_i,
    output logic [DATA_WIDTH-1:0] d_mem_data_o,
    input  logic                  cpu_hold_i,
    output logic                  host_own_o,
    input  logic                  host_req_i,
    input  logic                  host_wen_i,
    input  logic [ADDR_WIDTH-1:0] host_addr_i,
    input  logic [DATA_WIDTH-1:0] host_wdata_i,
    output logic                  host_ready_o,
    output logic                  host_rvalid_o,
    output logic [DATA_WIDTH-1:0] host_rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        CPU_OWN  = 2'd0,
        DRAIN    = 2'd1,
        HOST_OWN = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   d_mem_data_q, d_mem_data_d;
    logic [DATA_WIDTH-1:0]   host_rdata_q, host_rdata_d;
    logic                    host_rvalid_q, host_rvalid_d;

    // Storage array, single write port shared by the two masters.
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic                    host_ready;
    logic                    host_fire;

    // -------------------------------------------------------------------------
    // Next-state, write-port and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        d_mem_data_d  = d_mem_data_q;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = d_mem_addr_i;
        mem_wdata     = d_mem_data_i;

        // Ready drops as soon as the hold is released, so nothing new is
        // accepted while handing the array back. It is also low in a reset
        // cycle: a handshake there would be lost because reset wins.
        host_ready = (state_q == HOST_OWN) && cpu_hold_i && !rst;
        host_fire  = host_req_i && host_ready;

        unique case (state_q)
            CPU_OWN: begin
                mem_we = d_mem_wen_i && !rst;
                // Write-first: a store and load of the same address in one
                // cycle return the store data. The CPU port has one address,
                // so any store in this cycle targets the read address.
                if (d_mem_wen_i) begin
                    d_mem_data_d = d_mem_data_i;
                end else begin
                    d_mem_data_d = mem_q[d_mem_addr_i];
                end
                if (cpu_hold_i) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                state_d = HOST_OWN;
            end

            HOST_OWN: begin
                if (host_fire) begin
                    if (host_wen_i) begin
                        mem_we    = 1'b1;
                        mem_waddr = host_addr_i;
                        mem_wdata = host_wdata_i;
                    end else begin
                        host_rdata_d  = mem_q[host_addr_i];
                        host_rvalid_d = 1'b1;
                    end
                end
                // A read accepted in the previous cycle is answered by the
                // rvalid register in this cycle, so it never blocks release.
                // Only a handshake in this cycle would, and ready is already
                // low once the hold drops.
                if (!cpu_hold_i && !host_fire) begin
                    state_d = CPU_OWN;
                end
            end

            default: begin
                state_d = CPU_OWN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= CPU_OWN;
            d_mem_data_q  <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            d_mem_data_q  <= d_mem_data_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    // Array contents survive reset; mem_we is already low during reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign d_mem_data_o  = d_mem_data_q;
    assign host_own_o    = (state_q == HOST_OWN);
    assign host_ready_o  = host_ready;
    assign host_rvalid_o = host_rvalid_q;
    assign host_rdata_o  = host_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder: directed scenarios for the CPU path,
// ownership handover, host reads/writes, release and reset, followed by a
// randomized phase. A behavioural model (array + ownership mode) predicts
// every output each cycle.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int AW    = 8;
  localparam int DW    = 64;
  localparam int DEPTH = 1 << AW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_wen;
  logic [DW-1:0] d_mem_data_o;
  logic          hold;
  logic          host_own_o;
  logic          req;
  logic          hwen;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic          host_ready_o;
  logic          host_rvalid_o;
  logic [DW-1:0] host_rdata_o;

  dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .d_mem_addr_i (d_addr),
    .d_mem_data_i (d_wdata),
    .d_mem_wen_i  (d_wen),
    .d_mem_data_o (d_mem_data_o),
    .cpu_hold_i   (hold),
    .host_own_o   (host_own_o),
    .host_req_i   (req),
    .host_wen_i   (hwen),
    .host_addr_i  (haddr),
    .host_wdata_i (hwdata),
    .host_ready_o (host_ready_o),
    .host_rvalid_o(host_rvalid_o),
    .host_rdata_o (host_rdata_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  localparam int M_CPU = 0, M_DRAIN = 1, M_HOST = 2;
  logic [DW-1:0] m_mem [DEPTH];
  int            m_mode;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] m_rdata;
  logic          m_rvalid;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one rising edge of the specified behaviour to the model.
  task automatic model_edge();
    logic fire;
    fire = (m_mode == M_HOST) && hold && !rst && req;
    if (rst) begin
      m_mode   = M_CPU;
      m_dout   = '0;
      m_rdata  = '0;
      m_rvalid = 1'b0;
    end else begin
      m_rvalid = 1'b0;
      case (m_mode)
        M_CPU: begin
          if (d_wen) m_mem[d_addr] = d_wdata;
          m_dout = m_mem[d_addr];
          if (hold) m_mode = M_DRAIN;
        end
        M_DRAIN: m_mode = M_HOST;
        default: begin
          if (fire) begin
            if (hwen) m_mem[haddr] = hwdata;
            else begin
              m_rdata  = m_mem[haddr];
              m_rvalid = 1'b1;
            end
          end
          if (!hold && !fire) m_mode = M_CPU;
        end
      endcase
    end
  endtask

  // One clock cycle: check combinational outputs, clock, check registers.
  task automatic tick();
    #1;
    check_eq("host_ready", host_ready_o, (m_mode == M_HOST) && hold && !rst);
    check_eq("host_own", host_own_o, m_mode == M_HOST);
    @(posedge clk);
    model_edge();
    #1;
    check_eq("d_mem_data", d_mem_data_o, m_dout);
    check_eq("host_rvalid", host_rvalid_o, m_rvalid);
    check_eq("host_rdata", host_rdata_o, m_rdata);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_idle();
    d_wen  = 1'b0;
    req    = 1'b0;
    hwen   = 1'b0;
  endtask

  task automatic enter_host();
    hold = 1'b1;
    tick();  // CPU_OWN cycle sampling the hold
    tick();  // DRAIN cycle
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [DW-1:0] m3;

  initial begin
    rst = 1'b1; d_addr = '0; d_wdata = '0; d_wen = 1'b0;
    hold = 1'b0; req = 1'b0; hwen = 1'b0; haddr = '0; hwdata = '0;
    m_mode = M_CPU; m_dout = '0; m_rdata = '0; m_rvalid = 1'b0;

    // Bring the DUT out of its unknown power-up state, then check reset values.
    @(posedge clk);
    #1;
    tick();
    check_eq("rst_dout", d_mem_data_o, '0);
    check_eq("rst_rvalid", host_rvalid_o, '0);
    rst = 1'b0;

    // Fill the whole array from the CPU side so every read is defined.
    for (int a = 0; a < DEPTH; a++) begin
      d_addr  = AW'(a);
      d_wen   = 1'b1;
      d_wdata = {$urandom, $urandom};
      tick();
    end

    // Store then load.
    d_addr = 8'd5; d_wdata = 64'hDEAD_BEEF_0000_0001; d_wen = 1'b1;
    tick();
    d_wen = 1'b0;
    tick();
    check_eq("cpu_load5", d_mem_data_o, 64'hDEAD_BEEF_0000_0001);

    // Write-first on a same-cycle store and load.
    d_addr = 8'd7; d_wdata = 64'h11; d_wen = 1'b1;
    tick();
    check_eq("write_first7", d_mem_data_o, 64'h11);
    d_wen = 1'b0;

    // Hold handover; CPU stores to addr 3 in DRAIN and first HOST cycle.
    m3   = m_mem[3];
    hold = 1'b1;
    tick();
    d_addr = 8'd3; d_wdata = 64'hBAD; d_wen = 1'b1;
    #1;
    check_eq("ready_in_drain", host_ready_o, 1'b0);
    tick();
    req = 1'b1; hwen = 1'b1; haddr = 8'h20; hwdata = 64'hA5;
    #1;
    check_eq("ready_first_host", host_ready_o, 1'b1);
    tick();
    d_wen = 1'b0;

    // Back-to-back host reads.
    hwen = 1'b0; haddr = 8'h20;
    tick();
    check_eq("hrd_20_valid", host_rvalid_o, 1'b1);
    check_eq("hrd_20_data", host_rdata_o, 64'hA5);
    haddr = 8'd5;
    tick();
    check_eq("hrd_5_valid", host_rvalid_o, 1'b1);
    check_eq("hrd_5_data", host_rdata_o, 64'hDEAD_BEEF_0000_0001);
    haddr = 8'd3;
    tick();
    check_eq("mem3_kept", host_rdata_o, m3);
    req = 1'b0;
    tick();
    check_eq("no_rvalid_idle", host_rvalid_o, 1'b0);

    // Release and CPU readback of the host write.
    hold = 1'b0;
    tick();
    check_eq("own_released", host_own_o, 1'b0);
    d_addr = 8'h20;
    tick();
    check_eq("cpu_sees_host_wr", d_mem_data_o, 64'hA5);

    // Hold drops in the cycle right after a read is accepted.
    enter_host();
    req = 1'b1; hwen = 1'b0; haddr = 8'd5;
    tick();
    check_eq("rel_rvalid", host_rvalid_o, 1'b1);
    check_eq("rel_rdata", host_rdata_o, 64'hDEAD_BEEF_0000_0001);
    hold = 1'b0; haddr = 8'd6;
    #1;
    check_eq("rel_ready_low", host_ready_o, 1'b0);
    tick();
    check_eq("rel_own_low", host_own_o, 1'b0);
    check_eq("rel_no_extra", host_rvalid_o, 1'b0);
    tick();
    check_eq("rel_stall", host_rvalid_o, 1'b0);
    drive_idle();

    // Reset while a read response is outstanding.
    enter_host();
    req = 1'b1; hwen = 1'b1; haddr = 8'h30; hwdata = 64'h55;
    tick();
    hwen = 1'b0;
    tick();
    rst = 1'b1; req = 1'b0; hold = 1'b0;
    tick();
    check_eq("rst_mid_rvalid", host_rvalid_o, 1'b0);
    check_eq("rst_mid_rdata", host_rdata_o, '0);
    check_eq("rst_mid_dout", d_mem_data_o, '0);
    check_eq("rst_mid_own", host_own_o, 1'b0);
    rst = 1'b0; d_addr = 8'h30;
    tick();
    check_eq("cpu_after_rst", d_mem_data_o, 64'h55);

    // Reset coinciding with a host request: nothing is accepted.
    enter_host();
    req = 1'b1; hwen = 1'b0; haddr = 8'h30; rst = 1'b1;
    tick();
    check_eq("rst_req_rvalid", host_rvalid_o, 1'b0);
    rst = 1'b0; hold = 1'b0;
    drive_idle();
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) hold = ~hold;
      rst     = ($urandom_range(0, 299) == 0);
      d_addr  = AW'($urandom_range(0, DEPTH - 1));
      d_wen   = $urandom_range(0, 1) == 1;
      d_wdata = {$urandom, $urandom};
      req     = $urandom_range(0, 2) != 0;
      hwen    = $urandom_range(0, 1) == 1;
      haddr   = AW'($urandom_range(0, DEPTH - 1));
      hwdata  = {$urandom, $urandom};
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
